// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encodings and bus-level bit constants
// used by the target and by the master's state monitor.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    RX        = 4'd3,
    RX_ACK    = 4'd4,
    TX        = 4'd5,
    TX_ACK    = 4'd6,
    WAIT_STOP = 4'd7
  } state_e;

  localparam logic WRITE = 1'b0;
  localparam logic READ  = 1'b1;
  localparam logic ACK   = 1'b0;
  localparam logic NACK  = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Synchroniser for one asynchronous bus line plus a history flop that
// yields single-cycle rise/fall strobes on the synchronised level.
module i2c_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              hist_r;

  // Idle bus lines are high, so reset to 1 to avoid a spurious edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= '1;
      hist_r <= 1'b1;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], din};
      hist_r <= sync_r[STAGES-1];
    end
  end

  assign level = sync_r[STAGES-1];
  assign rise  = sync_r[STAGES-1] & ~hist_r;
  assign fall  = ~sync_r[STAGES-1] & hist_r;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: address match, byte receive/transmit with ACK handling and
// open-drain sda drive, all paced by oversampled sclk/sda edges.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic [3:0] state
);

  logic   scl_lvl_s, scl_rise_s, scl_fall_s;
  logic   sda_lvl_s, sda_rise_s, sda_fall_s;
  logic   start_s, stop_s;
  state_e state_r;
  logic [3:0] bit_cnt_r;
  logic [7:0] shift_r;
  logic   rw_r;
  logic   sda_low_r;
  logic   ack_ok_r;

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl (
    .clk(clk), .rst(rst), .din(sclk),
    .level(scl_lvl_s), .rise(scl_rise_s), .fall(scl_fall_s)
  );

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda (
    .clk(clk), .rst(rst), .din(sda),
    .level(sda_lvl_s), .rise(sda_rise_s), .fall(sda_fall_s)
  );

  assign start_s = sda_fall_s & scl_lvl_s;
  assign stop_s  = sda_rise_s & scl_lvl_s;
  assign sda     = sda_low_r ? 1'b0 : 1'bz;
  assign state   = state_r;

  // Protocol FSM; bus conditions pre-empt whatever byte is in flight.
  always_ff @(posedge clk) begin
    rx_valid <= 1'b0;
    tx_req   <= 1'b0;
    if (rst) begin
      state_r   <= IDLE;
      bit_cnt_r <= 4'd0;
      shift_r   <= 8'h00;
      rw_r      <= WRITE;
      sda_low_r <= 1'b0;
      ack_ok_r  <= 1'b0;
      rx_data   <= 8'h00;
    end else if (stop_s) begin
      state_r   <= IDLE;
      bit_cnt_r <= 4'd0;
      sda_low_r <= 1'b0;
      ack_ok_r  <= 1'b0;
    end else if (start_s) begin
      state_r   <= ADDR;
      bit_cnt_r <= 4'd0;
      sda_low_r <= 1'b0;
      ack_ok_r  <= 1'b0;
    end else begin
      case (state_r)
        ADDR: if (scl_rise_s) begin
          shift_r <= {shift_r[6:0], sda_lvl_s};
          if (bit_cnt_r == 4'd7) begin
            bit_cnt_r <= 4'd0;
            rw_r      <= sda_lvl_s;
            state_r   <= (shift_r[6:0] == SLAVE_ADDR) ? ADDR_ACK : WAIT_STOP;
          end else begin
            bit_cnt_r <= bit_cnt_r + 4'd1;
          end
        end
        // First fall after the byte pulls sda low, the next one releases it.
        ADDR_ACK, RX_ACK: if (scl_fall_s) begin
          if (!sda_low_r) begin
            sda_low_r <= 1'b1;
          end else if (state_r == RX_ACK || rw_r == WRITE) begin
            sda_low_r <= 1'b0;
            state_r   <= RX;
          end else begin
            tx_req    <= 1'b1;
            shift_r   <= tx_data;
            sda_low_r <= ~tx_data[7];
            bit_cnt_r <= 4'd1;
            state_r   <= TX;
          end
        end
        RX: if (scl_rise_s) begin
          shift_r <= {shift_r[6:0], sda_lvl_s};
          if (bit_cnt_r == 4'd7) begin
            rx_data   <= {shift_r[6:0], sda_lvl_s};
            rx_valid  <= 1'b1;
            bit_cnt_r <= 4'd0;
            state_r   <= RX_ACK;
          end else begin
            bit_cnt_r <= bit_cnt_r + 4'd1;
          end
        end
        // bit_cnt_r counts bits already placed on the line.
        TX: if (scl_fall_s) begin
          if (bit_cnt_r == 4'd8) begin
            sda_low_r <= 1'b0;
            bit_cnt_r <= 4'd0;
            ack_ok_r  <= 1'b0;
            state_r   <= TX_ACK;
          end else begin
            sda_low_r <= ~shift_r[6];
            shift_r   <= {shift_r[6:0], 1'b0};
            bit_cnt_r <= bit_cnt_r + 4'd1;
          end
        end
        TX_ACK: begin
          if (scl_rise_s) begin
            if (sda_lvl_s == NACK) begin
              state_r <= WAIT_STOP;
            end else begin
              ack_ok_r <= 1'b1;
            end
          end else if (scl_fall_s && ack_ok_r) begin
            ack_ok_r  <= 1'b0;
            tx_req    <= 1'b1;
            shift_r   <= tx_data;
            sda_low_r <= ~tx_data[7];
            bit_cnt_r <= 4'd1;
            state_r   <= TX;
          end
        end
        IDLE, WAIT_STOP: sda_low_r <= 1'b0;
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-banged I2C master drives randomised transfers
// and a transaction-level model predicts acks, received and returned bytes.
module tb_i2c_slave;
  import i2c_pkg::*;

  localparam int Q = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b1;
  logic       m_low = 1'b0;
  wire        sda;
  logic [7:0] tx_data = 8'hFF;
  logic       tx_req;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] state;

  int total = 0;
  int bad = 0;
  int rx_cnt = 0;
  int tx_cnt = 0;
  int inv_bad = 0;
  int drove_cnt = 0;
  logic [7:0] rx_q[$];
  logic [7:0] txq[$];
  logic [7:0] exp_rx = 8'h00;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .sda(sda), .tx_data(tx_data),
    .tx_req(tx_req), .rx_data(rx_data), .rx_valid(rx_valid), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Pulse monitor, tx byte supply and invariant tracking.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      rx_q.push_back(rx_data);
    end
    if (tx_req) begin
      tx_cnt++;
      if (txq.size() > 0) void'(txq.pop_front());
    end
    tx_data = (txq.size() > 0) ? txq[0] : 8'hFF;
    if ((rx_valid && tx_req) ||
        ((rx_valid || tx_req) && (state == 4'd0 || state == 4'd7)))
      inv_bad++;
    if (!m_low && sda === 1'b0) drove_cnt++;
  end

  task automatic start_c;
    m_low = 1'b1; #(2*Q); sclk = 1'b0; #(Q);
  endtask

  task automatic rstart_c;
    m_low = 1'b0; #(Q); sclk = 1'b1; #(2*Q); m_low = 1'b1; #(2*Q); sclk = 1'b0; #(Q);
  endtask

  task automatic stop_c;
    m_low = 1'b1; #(Q); sclk = 1'b1; #(2*Q); m_low = 1'b0; #(2*Q);
  endtask

  task automatic clock_bit(input logic b, output logic s);
    m_low = ~b; #(Q); sclk = 1'b1; #(Q); s = sda; #(Q); sclk = 1'b0; #(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, s);
      d = {d[6:0], s};
    end
    clock_bit(nack, s);
  endtask

  task automatic test_reset;
    repeat (5) @(negedge clk);
    total += 5;
    if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    if (tx_req !== 1'b0) begin bad++; $display("FAIL reset_tx_req: got %b want 0", tx_req); end
    if (state !== 4'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
    if (sda !== 1'b1) begin bad++; $display("FAIL reset_sda: got %b want released", sda); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_write(input logic [7:0] first, input int n);
    logic [7:0] exp[$];
    logic [7:0] b;
    logic ack;
    int r0 = rx_q.size();
    int c0 = rx_cnt;
    start_c;
    write_byte({7'h50, WRITE}, ack);
    total++;
    if (ack !== ACK) begin bad++; $display("FAIL write_addr_ack: got %b want 0", ack); end
    for (int i = 0; i < n; i++) begin
      b = (i == 0) ? first : 8'($urandom);
      exp.push_back(b);
      write_byte(b, ack);
      total++;
      if (ack !== ACK) begin bad++; $display("FAIL write_data_ack: byte %0d got %b want 0", i, ack); end
    end
    stop_c;
    repeat (10) @(negedge clk);
    exp_rx = exp[n-1];
    total += 3;
    if (rx_cnt - c0 !== n) begin bad++; $display("FAIL write_rx_count: got %0d want %0d", rx_cnt - c0, n); end
    if (rx_data !== exp_rx) begin bad++; $display("FAIL write_rx_data: got %h want %h", rx_data, exp_rx); end
    if (state !== 4'd0) begin bad++; $display("FAIL write_end_state: got %0d want 0", state); end
    for (int i = 0; i < n; i++) begin
      total++;
      if (rx_q.size() <= r0 + i || rx_q[r0+i] !== exp[i]) begin
        bad++;
        $display("FAIL write_rx_seq: byte %0d got %h want %h", i,
                 (rx_q.size() > r0 + i) ? rx_q[r0+i] : 8'hxx, exp[i]);
      end
    end
  endtask

  task automatic test_read(input logic [7:0] b0, input logic [7:0] b1, input int n);
    logic [7:0] exp[$];
    logic [7:0] d;
    logic ack;
    int t0 = tx_cnt;
    int c0 = rx_cnt;
    for (int i = 0; i < n; i++) begin
      d = (i == 0) ? b0 : (i == 1) ? b1 : 8'($urandom);
      exp.push_back(d);
      txq.push_back(d);
    end
    repeat (2) @(negedge clk);
    start_c;
    write_byte({7'h50, READ}, ack);
    total++;
    if (ack !== ACK) begin bad++; $display("FAIL read_addr_ack: got %b want 0", ack); end
    for (int i = 0; i < n; i++) begin
      read_byte((i == n - 1) ? NACK : ACK, d);
      total++;
      if (d !== exp[i]) begin bad++; $display("FAIL read_data: byte %0d got %h want %h", i, d, exp[i]); end
    end
    @(negedge clk);
    total++;
    if (state !== 4'd7) begin bad++; $display("FAIL read_after_nack_state: got %0d want 7", state); end
    stop_c;
    repeat (10) @(negedge clk);
    total += 3;
    if (state !== 4'd0) begin bad++; $display("FAIL read_end_state: got %0d want 0", state); end
    if (tx_cnt - t0 !== n) begin bad++; $display("FAIL read_tx_req_count: got %0d want %0d", tx_cnt - t0, n); end
    if (rx_cnt - c0 !== 0) begin bad++; $display("FAIL read_rx_count: got %0d want 0", rx_cnt - c0); end
  endtask

  task automatic test_mismatch(input logic [6:0] addr, input logic rw);
    logic ack;
    int d0 = drove_cnt;
    int t0 = tx_cnt;
    int c0 = rx_cnt;
    start_c;
    write_byte({addr, rw}, ack);
    total++;
    if (ack !== NACK) begin bad++; $display("FAIL mismatch_ack: addr %h got %b want 1", addr, ack); end
    write_byte(8'($urandom), ack);
    @(negedge clk);
    total++;
    if (state !== 4'd7) begin bad++; $display("FAIL mismatch_state: got %0d want 7", state); end
    stop_c;
    repeat (10) @(negedge clk);
    total += 3;
    if (state !== 4'd0) begin bad++; $display("FAIL mismatch_end_state: got %0d want 0", state); end
    if (drove_cnt - d0 !== 0) begin bad++; $display("FAIL mismatch_sda_driven: got %0d cycles want 0", drove_cnt - d0); end
    if ((tx_cnt - t0) + (rx_cnt - c0) !== 0) begin
      bad++; $display("FAIL mismatch_pulses: got %0d want 0", (tx_cnt - t0) + (rx_cnt - c0));
    end
  endtask

  task automatic test_repeated_start;
    logic ack;
    logic [7:0] d;
    logic [7:0] tb = 8'($urandom);
    int t0 = tx_cnt;
    int c0 = rx_cnt;
    int r0 = rx_q.size();
    txq.push_back(tb);
    start_c;
    write_byte({7'h50, WRITE}, ack);
    write_byte(8'h10, ack);
    total++;
    if (ack !== ACK) begin bad++; $display("FAIL rs_data_ack: got %b want 0", ack); end
    exp_rx = 8'h10;
    rstart_c;
    write_byte({7'h50, READ}, ack);
    total++;
    if (ack !== ACK) begin bad++; $display("FAIL rs_addr_ack: got %b want 0", ack); end
    read_byte(NACK, d);
    stop_c;
    repeat (10) @(negedge clk);
    total += 4;
    if (d !== tb) begin bad++; $display("FAIL rs_read_data: got %h want %h", d, tb); end
    if (rx_cnt - c0 !== 1) begin bad++; $display("FAIL rs_rx_count: got %0d want 1", rx_cnt - c0); end
    if (rx_q.size() <= r0 || rx_q[r0] !== 8'h10) begin bad++; $display("FAIL rs_rx_data: got %h want 10", rx_data); end
    if (tx_cnt - t0 !== 1) begin bad++; $display("FAIL rs_tx_req_count: got %0d want 1", tx_cnt - t0); end
  endtask

  task automatic test_stop_mid;
    logic ack;
    logic s;
    int c0 = rx_cnt;
    start_c;
    write_byte({7'h50, WRITE}, ack);
    for (int i = 0; i < 4; i++) clock_bit(1'($urandom), s);
    stop_c;
    repeat (10) @(negedge clk);
    total += 3;
    if (state !== 4'd0) begin bad++; $display("FAIL stopmid_state: got %0d want 0", state); end
    if (rx_cnt - c0 !== 0) begin bad++; $display("FAIL stopmid_rx_valid: got %0d pulses want 0", rx_cnt - c0); end
    if (rx_data !== exp_rx) begin bad++; $display("FAIL stopmid_rx_data: got %h want %h", rx_data, exp_rx); end
  endtask

  task automatic test_reset_mid_ack;
    logic [7:0] a = {7'h50, WRITE};
    logic s;
    bit seen = 1'b0;
    start_c;
    for (int i = 7; i >= 0; i--) clock_bit(a[i], s);
    m_low = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (sda === 1'b0) seen = 1'b1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL rstack_ack_driven: got released want low"); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (sda !== 1'b1) begin bad++; $display("FAIL rstack_sda_release: got %b want released", sda); end
    @(negedge clk);
    exp_rx = 8'h00;
    total += 4;
    if (state !== 4'd0) begin bad++; $display("FAIL rstack_state: got %0d want 0", state); end
    if (rx_data !== 8'h00) begin bad++; $display("FAIL rstack_rx_data: got %h want 00", rx_data); end
    if (rx_valid !== 1'b0) begin bad++; $display("FAIL rstack_rx_valid: got %b want 0", rx_valid); end
    if (tx_req !== 1'b0) begin bad++; $display("FAIL rstack_tx_req: got %b want 0", tx_req); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    sclk = 1'b1;
    #(2*Q);
    test_write(8'($urandom), 2);
  endtask

  task automatic test_invariants;
    total++;
    if (inv_bad !== 0) begin bad++; $display("FAIL pulse_invariants: got %0d violations want 0", inv_bad); end
  endtask

  initial begin
    test_reset;
    test_write(8'hA5, 1);
    test_write(8'($urandom), 3);
    test_read(8'h3C, 8'hC3, 2);
    test_read(8'($urandom), 8'($urandom), 3);
    test_mismatch(7'h51, WRITE);
    for (int i = 0; i < 3; i++) begin
      logic [6:0] a;
      a = 7'($urandom);
      if (a == 7'h50) a = 7'h2A;
      test_mismatch(a, 1'($urandom));
    end
    test_repeated_start;
    test_stop_mid;
    test_reset_mid_ack;
    test_invariants;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
I2C target (slave) that answers the existing `master` block on the same two-wire bus. It oversamples sclk and sda on the system clock and detects START and STOP conditions. It matches a 7-bit address, then either receives bytes (master write) or sends bytes (master read), with ACK/NACK handling and open-drain sda drive. It gives the benches and the top level a real bus partner for the master.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit bus address this target responds to
SYNC_STAGES, 2, flip-flop stages in the sclk/sda input synchronisers (legal: 2 or 3)

Ports:
clk  input  1  system clock; must be at least 8x the sclk frequency
rst  input  1  synchronous active-high reset
sclk  input  1  I2C clock from the master (asynchronous to clk)
sda  inout  1  I2C data line, open-drain: this block drives 0 or z only
tx_data  input  8  byte to return on the next read byte; sampled when tx_req is high
tx_req  output  1  one-cycle pulse: tx_data is captured this cycle
rx_data  output  8  last byte received from the master
rx_valid  output  1  one-cycle pulse: rx_data is updated
state  output  4  current FSM state encoding, for monitoring

Behaviour:
- Reset values: rx_data=8'h00, rx_valid=0, tx_req=0, state=IDLE, sda released (z), bit counter=0.
- Synchronisers: sclk and sda each pass through SYNC_STAGES flops, plus one history flop for edge detection.
  - A pin change is acted on SYNC_STAGES+1 clk cycles later.
- Bus events, evaluated on synchronised signals:
  - START: sda falls while sclk is high.
  - STOP: sda rises while sclk is high.
  - Data bits are sampled on sclk rising edges.
  - Slave sda changes happen only on sclk falling edges.
- States and encodings: IDLE=0, ADDR=1, ADDR_ACK=2, RX=3, RX_ACK=4, TX=5, TX_ACK=6, WAIT_STOP=7.
- IDLE: on START, clear the bit counter and go to ADDR.
- ADDR: shift 8 bits MSB first (7 address bits, then R/W).
  - After the 8th rising edge: if the address equals SLAVE_ADDR, go to ADDR_ACK; otherwise go to WAIT_STOP (sda never driven).
- ADDR_ACK: drive sda low from the next sclk fall until the following sclk fall (the 9th clock).
  - If R/W=0: go to RX at the release.
  - If R/W=1: pulse tx_req and load tx_data into the shift register on the same sclk fall that releases the ACK, drive bit 7, and go to TX.
- RX: shift 8 bits.
  - On the 8th rising edge: rx_data <= shifted byte and pulse rx_valid for one cycle.
  - Then go to RX_ACK.
- RX_ACK: drive ACK (low) for the 9th clock, exactly as in ADDR_ACK, then return to RX for the next byte.
- TX: on each sclk fall present the next bit; a 1 is sent as release (z), a 0 as drive low.
  - After the 8th bit's sclk fall, release sda and go to TX_ACK.
- TX_ACK: sample sda on the 9th rising edge.
  - ACK (0): on the next fall pulse tx_req, load tx_data, drive bit 7, and go to TX.
  - NACK (1): go to WAIT_STOP.
- WAIT_STOP: sda released; ignore the bus until STOP (go to IDLE) or START (go to ADDR).
- Priority:
  - STOP in any state: go to IDLE and release sda in the same cycle.
  - START (including a repeated START) in any state: go to ADDR, release sda, clear the counter.
  - A partial byte is discarded; rx_valid does not fire for it.
- rst overrides everything: sda is released the cycle after rst is sampled high.
- Bit counter is 4 bits and wraps to 0 on each byte boundary; it never exceeds 8.
- rx_valid and tx_req are never high in the same cycle, and never high in IDLE or WAIT_STOP.

Decomposition:
- Shared package i2c_pkg holds:
  - state encodings (IDLE..WAIT_STOP, 4 bits), shared with `master`'s state monitor width;
  - R/W bit constants (WRITE=0, READ=1);
  - ACK=0 and NACK=1 constants.
- One sub-module is natural: i2c_sync_edge.
  - Parameterised synchroniser plus edge detector for one line.
  - Outputs: level, rise, fall.
  - Instantiated once for sclk and once for sda.

Test Plan:
- Write byte: START, 0xA0 (addr 0x50, W), ACK sampled 0, byte 0xA5, STOP -> rx_data=0xA5, rx_valid exactly one pulse, state returns to 0.
- Read two bytes: START, 0xA1; tx_data=0x3C then 0xC3; master ACKs the first byte and NACKs the second -> sda carries 00111100 then 11000011, tx_req pulses twice, state 7 then 0 after STOP.
- Address mismatch: START, 0xA2 (addr 0x51) -> sda stays z for all 9 clocks, no rx_valid or tx_req, state=7 until STOP.
- Repeated START: write 0xA0 and register byte 0x10, then repeated START with 0xA1 (no STOP) -> rx_valid once with 0x10, then TX path entered with tx_req pulse.
- STOP mid-byte: after 4 data bits of a write, issue STOP -> state=0, no rx_valid, rx_data unchanged.
- Reset mid-ACK: assert rst while the slave is driving an ACK low -> sda z the next cycle, all outputs at reset values; the next full transaction succeeds.
